// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Shared 640x480@60 raster constants and helpers for timing/colour
// Revision : 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    localparam logic VGA_SYNC_POL   = 1'b0;
    localparam int   VGA_PIPE_DELAY = 1;

    // Signals that travel through the colour-stage latency compensation line.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } sync_bus_t;

    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_delay.sv
// ============================================================================
// Module   : sync_delay
// Brief    : Clock-enable gated shift register; DEPTH=0 is a plain wire
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_delay #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, reset, ce};
            assign dout        = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stages[i] <= RESET_VAL;
                    end
                end else if (ce) begin
                    stages[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing.sv
// ============================================================================
// Module   : vga_timing
// Brief    : Raster counters, coordinate/sync decode and line/frame pulses
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE  = VGA_H_VISIBLE,
    parameter int   H_FRONT    = VGA_H_FRONT,
    parameter int   H_SYNC     = VGA_H_SYNC,
    parameter int   H_BACK     = VGA_H_BACK,
    parameter int   V_VISIBLE  = VGA_V_VISIBLE,
    parameter int   V_FRONT    = VGA_V_FRONT,
    parameter int   V_SYNC     = VGA_V_SYNC,
    parameter int   V_BACK     = VGA_V_BACK,
    parameter logic SYNC_POL   = VGA_SYNC_POL,
    parameter int   PIPE_DELAY = VGA_PIPE_DELAY
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic               blank
);

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    generate
        if (H_TOTAL > (1 << COORD_W)) begin : g_h_total_check
            $error("vga_timing: H_TOTAL does not fit the 10-bit horizontal counter");
        end
        if (V_TOTAL > (1 << COORD_W)) begin : g_v_total_check
            $error("vga_timing: V_TOTAL does not fit the 10-bit vertical counter");
        end
        if ((PIPE_DELAY < 0) || (PIPE_DELAY > 7)) begin : g_pipe_check
            $error("vga_timing: PIPE_DELAY must be within 0..7");
        end
    endgenerate

    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] H_SS   = COORD_W'(H_SYNC_START);
    localparam logic [COORD_W-1:0] H_SE   = COORD_W'(H_SYNC_END);
    localparam logic [COORD_W-1:0] V_SS   = COORD_W'(V_SYNC_START);
    localparam logic [COORD_W-1:0] V_SE   = COORD_W'(V_SYNC_END);

    logic [COORD_W-1:0] hcnt;
    logic [COORD_W-1:0] vcnt;
    logic [COORD_W-1:0] hcnt_next;
    logic [COORD_W-1:0] vcnt_next;
    logic               h_wrap;
    logic               v_wrap;
    logic               h_vis_next;
    logic               v_vis_next;
    logic               hsync_next;
    logic               vsync_next;
    logic               hsync_raw;
    logic               vsync_raw;
    sync_bus_t          sync_raw;
    sync_bus_t          sync_out;

    // Everything registered is decoded from the post-edge counter values so
    // x/y/active line up with hcnt/vcnt with no skew.
    always_comb begin
        h_wrap    = (hcnt == H_LAST);
        v_wrap    = h_wrap && (vcnt == V_LAST);
        hcnt_next = h_wrap ? '0 : hcnt + ONE;
        vcnt_next = vcnt;
        if (v_wrap) begin
            vcnt_next = '0;
        end else if (h_wrap) begin
            vcnt_next = vcnt + ONE;
        end
        h_vis_next = (hcnt_next < H_VIS);
        v_vis_next = (vcnt_next < V_VIS);
        hsync_next = sync_level((hcnt_next >= H_SS) && (hcnt_next <= H_SE), SYNC_POL);
        vsync_next = sync_level((vcnt_next >= V_SS) && (vcnt_next <= V_SE), SYNC_POL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt        <= '0;
            vcnt        <= '0;
            x           <= '0;
            y           <= '0;
            active      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync_raw   <= ~SYNC_POL;
            vsync_raw   <= ~SYNC_POL;
        end else if (ce) begin
            hcnt        <= hcnt_next;
            vcnt        <= vcnt_next;
            x           <= h_vis_next ? hcnt_next : '0;
            y           <= v_vis_next ? vcnt_next : '0;
            active      <= h_vis_next && v_vis_next;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            hsync_raw   <= hsync_next;
            vsync_raw   <= vsync_next;
        end
    end

    // Syncs and blank are retimed to match the colour stage's pixel latency.
    assign sync_raw = '{hsync: hsync_raw, vsync: vsync_raw, blank: ~active};

    sync_delay #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL ({~SYNC_POL, ~SYNC_POL, 1'b1})
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .din   (sync_raw),
        .dout  (sync_out)
    );

    assign hsync = sync_out.hsync;
    assign vsync = sync_out.vsync;
    assign blank = sync_out.blank;

endmodule

`default_nettype wire
